input_sequencer: RTL and testbench

INPUT_SEQUENCER -- requirements
Module: input_sequencer

---
 rtl/input_sequencer_if.sv | 28 ++
 rtl/input_sequencer.sv | 153 +++++++++++++++
 tb/tb_input_sequencer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/input_sequencer_if.sv
// Board-side bundle for input_sequencer: raw buttons/switches in, selected function and
// gated instruction words out.
interface input_sequencer_if;
    logic       East;
    logic       West;
    logic       North;
    logic       South;
    logic       SW0;
    logic       SW1;
    logic       SW2;
    logic       SW3;
    logic       change_button;
    logic [1:0] func_index;
    logic [3:0] func1_instruction;
    logic [3:0] func2_instruction;
    logic       reset;
    logic       change_pulse;

    modport master (
        output East, West, North, South, SW0, SW1, SW2, SW3, change_button,
        input  func_index, func1_instruction, func2_instruction, reset, change_pulse
    );

    modport slave (
        input  East, West, North, South, SW0, SW1, SW2, SW3, change_button,
        output func_index, func1_instruction, func2_instruction, reset, change_pulse
    );
endinterface

// File: rtl/input_sequencer.sv
// Synchronizes and debounces board inputs, cycles the active function on change_button and
// routes debounced inputs to that function's instruction word, blanked during a guard window.
module input_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned GUARD_CYCLES    = 2
) (
    input logic              clk,
    input logic              reset_n,
    input_sequencer_if.slave bus
);
    localparam int unsigned DebW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned GuardW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [DebW-1:0]   DebMax   = DebW'(DEBOUNCE_CYCLES - 1);
    localparam logic [GuardW-1:0] GuardMax = GuardW'(GUARD_CYCLES - 1);

    localparam logic [0:0] ACTIVE = 1'b0;
    localparam logic [0:0] GUARD  = 1'b1;

    // Bit order: 0 East, 1 West, 2 North, 3 South, 4..7 SW0..SW3, 8 change_button
    logic [8:0] raw, sync1, sync2, deb;

    assign raw = {bus.change_button, bus.SW3, bus.SW2, bus.SW1, bus.SW0,
                  bus.South, bus.North, bus.West, bus.East};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < 9; i++) begin : g_deb
        logic [DebW-1:0] cnt_q;
        logic            deb_q;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cnt_q <= '0;
                deb_q <= 1'b0;
            end else if (sync2[i] == deb_q) begin
                cnt_q <= '0;
            end else if (cnt_q == DebMax) begin
                deb_q <= sync2[i];
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + DebW'(1);
            end
        end

        assign deb[i] = deb_q;
    end

    // A button held through reset must be seen released before its edges count; the settle
    // count waits for the synchronizer to carry real pin values again.
    logic       cb_dly_q, armed_q;
    logic [1:0] settle_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cb_dly_q <= 1'b0;
            armed_q  <= 1'b0;
            settle_q <= 2'd0;
        end else begin
            cb_dly_q <= deb[8];
            if (settle_q != 2'd2) begin
                settle_q <= settle_q + 2'd1;
            end else if (!sync2[8]) begin
                armed_q <= 1'b1;
            end
        end
    end

    logic              state_q, state_d;
    logic [1:0]        func_q, func_d;
    logic [GuardW-1:0] gcnt_q, gcnt_d;
    logic              pulse_q, pulse_d;
    logic [3:0]        f1_q, f1_d, f2_q, f2_d;
    logic              rst_q;
    logic              advance;

    assign advance = deb[8] & ~cb_dly_q & armed_q;

    always_comb begin
        state_d = state_q;
        func_d  = func_q;
        gcnt_d  = gcnt_q;
        pulse_d = 1'b0;
        f1_d    = '0;
        f2_d    = '0;

        if (func_q == 2'd3) begin
            func_d = 2'd0;
        end

        unique case (state_q)
            ACTIVE: begin
                if (advance && !rst_q && func_q != 2'd3) begin
                    func_d  = (func_q == 2'd2) ? 2'd0 : func_q + 2'd1;
                    pulse_d = 1'b1;
                    state_d = GUARD;
                    gcnt_d  = '0;
                end
            end
            GUARD: begin
                if (gcnt_q == GuardMax) begin
                    state_d = ACTIVE;
                    gcnt_d  = '0;
                end else begin
                    gcnt_d = gcnt_q + GuardW'(1);
                end
            end
            default: state_d = ACTIVE;
        endcase

        // Outputs follow the next state so the blanking lines up with change_pulse.
        if (state_d == ACTIVE && func_q != 2'd3) begin
            case (func_d)
                2'd0:    f1_d = {deb[7], deb[6], deb[5], deb[0]};
                2'd1:    f2_d = {deb[0], deb[1], deb[2], deb[3]};
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ACTIVE;
            func_q  <= 2'd0;
            gcnt_q  <= '0;
            pulse_q <= 1'b0;
            f1_q    <= '0;
            f2_q    <= '0;
            rst_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            func_q  <= func_d;
            gcnt_q  <= gcnt_d;
            pulse_q <= pulse_d;
            f1_q    <= f1_d;
            f2_q    <= f2_d;
            rst_q   <= deb[4];
        end
    end

    assign bus.func_index        = func_q;
    assign bus.func1_instruction = f1_q;
    assign bus.func2_instruction = f2_q;
    assign bus.reset             = rst_q;
    assign bus.change_pulse      = pulse_q;
endmodule

// File: tb/tb_input_sequencer.sv
// Scoreboard bench for input_sequencer: timed expectations are queued as stimulus is applied
// and compared on the falling edge of the cycle they are due.
module tb_input_sequencer;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cycle = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   pulses = 0;
    int   pulses2 = 0;
    int   p0;

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    input_sequencer_if bus ();
    input_sequencer_if bus2 ();

    input_sequencer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    // Long guard so a second debounced press can land inside it.
    input_sequencer #(
        .DEBOUNCE_CYCLES (4),
        .GUARD_CYCLES    (16)
    ) dut2 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus2.slave)
    );

    typedef struct {
        string      tag;
        int         cyc;
        int         sel;
        logic [7:0] val;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_checks++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp_v, cycle);
    endtask

    function automatic logic [7:0] observe(input int sel);
        case (sel)
            0:       return {6'd0, bus.func_index};
            1:       return {4'd0, bus.func1_instruction};
            2:       return {4'd0, bus.func2_instruction};
            3:       return {7'd0, bus.reset};
            4:       return {7'd0, bus.change_pulse};
            5:       return {6'd0, bus2.func_index};
            default: return {7'd0, bus2.change_pulse};
        endcase
    endfunction

    task automatic expect_at(input string tag, input int off, input int sel, input logic [7:0] v);
        exp_t e;
        e.tag = tag;
        e.cyc = cycle + off;
        e.sel = sel;
        e.val = v;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin : monitor
        int i;
        if (bus.change_pulse) pulses++;
        if (bus2.change_pulse) pulses2++;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].cyc <= cycle) begin
                check(sb[i].tag, observe(sb[i].sel), sb[i].val);
                sb.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_func"}, {6'd0, bus.func_index}, 8'd0);
        check({tag, "_f1"}, {4'd0, bus.func1_instruction}, 8'd0);
        check({tag, "_f2"}, {4'd0, bus.func2_instruction}, 8'd0);
        check({tag, "_reset"}, {7'd0, bus.reset}, 8'd0);
        check({tag, "_pulse"}, {7'd0, bus.change_pulse}, 8'd0);
    endtask

    // Clean press: debounced rise 6 cycles after the pin, pulse/func one cycle later,
    // instruction words blanked for that cycle and the next.
    task automatic press_main(input logic [1:0] nxt, input logic [3:0] f1a, input logic [3:0] f2a);
        bus.change_button = 1'b1;
        expect_at("pulse_pre", 6, 4, 8'd0);
        expect_at("func_adv", 7, 0, {6'd0, nxt});
        expect_at("pulse_on", 7, 4, 8'd1);
        expect_at("guard_f1", 7, 1, 8'd0);
        expect_at("pulse_post", 8, 4, 8'd0);
        expect_at("guard_f2", 8, 2, 8'd0);
        expect_at("after_f1", 9, 1, {4'd0, f1a});
        expect_at("after_f2", 9, 2, {4'd0, f2a});
        wait_cyc(8);
        bus.change_button = 1'b0;
        wait_cyc(12);
    endtask

    initial begin
        {bus.East, bus.West, bus.North, bus.South} = '0;
        {bus.SW0, bus.SW1, bus.SW2, bus.SW3, bus.change_button} = '0;
        {bus2.East, bus2.West, bus2.North, bus2.South} = '0;
        {bus2.SW0, bus2.SW1, bus2.SW2, bus2.SW3, bus2.change_button} = '0;

        wait_cyc(3);
        check_all_zero("rst");
        reset_n = 1'b1;
        wait_cyc(4);

        // Stable input latency
        bus.SW3 = 1'b1;
        expect_at("sw3_early", 6, 1, 8'd0);
        expect_at("sw3_lat", 7, 1, 8'h8);
        expect_at("sw3_f2", 7, 2, 8'd0);
        wait_cyc(10);
        bus.SW3 = 1'b0;
        expect_at("sw3_clr", 7, 1, 8'd0);
        wait_cyc(10);

        // 3-cycle glitch filtered, 4-cycle pulse accepted
        bus.East = 1'b1;
        wait_cyc(3);
        bus.East = 1'b0;
        expect_at("glitch_a", 4, 1, 8'd0);
        expect_at("glitch_b", 7, 1, 8'd0);
        wait_cyc(10);
        bus.East = 1'b1;
        wait_cyc(4);
        bus.East = 1'b0;
        expect_at("east_on", 3, 1, 8'h1);
        expect_at("east_hold", 4, 1, 8'h1);
        wait_cyc(12);

        // Function cycling with input pattern f1=1011, f2=1010
        {bus.SW3, bus.SW1, bus.East, bus.North} = 4'hf;
        wait_cyc(10);
        expect_at("pat_f1", 1, 1, 8'hb);
        expect_at("pat_f2", 1, 2, 8'd0);
        wait_cyc(2);
        p0 = pulses;
        press_main(2'd1, 4'h0, 4'ha);
        press_main(2'd2, 4'h0, 4'h0);
        press_main(2'd0, 4'hb, 4'h0);
        check("pulse_cnt3", 8'(pulses - p0), 8'd3);

        // Soft reset blocks advancing
        p0 = pulses;
        bus.SW0 = 1'b1;
        expect_at("reset_early", 6, 3, 8'd0);
        expect_at("reset_on", 7, 3, 8'd1);
        wait_cyc(10);
        bus.change_button = 1'b1;
        expect_at("rst_hold_func", 9, 0, 8'd0);
        expect_at("rst_f1", 9, 1, 8'hb);
        expect_at("rst_still", 9, 3, 8'd1);
        wait_cyc(8);
        bus.change_button = 1'b0;
        wait_cyc(12);
        check("rst_no_pulse", 8'(pulses - p0), 8'd0);
        bus.SW0 = 1'b0;
        expect_at("reset_off", 7, 3, 8'd0);
        wait_cyc(10);

        // Hard reset inside GUARD at func 2, button held through it
        press_main(2'd1, 4'h0, 4'ha);
        bus.change_button = 1'b1;
        wait_cyc(7);
        check("pre_rst_func", {6'd0, bus.func_index}, 8'd2);
        check("pre_rst_pulse", {7'd0, bus.change_pulse}, 8'd1);
        reset_n = 1'b0;
        #1;
        check_all_zero("async");
        wait_cyc(2);
        reset_n = 1'b1;
        p0 = pulses;
        wait_cyc(20);
        check("held_no_pulse", 8'(pulses - p0), 8'd0);
        check("held_func", {6'd0, bus.func_index}, 8'd0);
        bus.change_button = 1'b0;
        wait_cyc(10);
        press_main(2'd1, 4'h0, 4'ha);

        // Second debounced press inside a long GUARD is dropped
        p0 = pulses2;
        bus2.change_button = 1'b1;
        expect_at("g2_pulse", 7, 6, 8'd1);
        expect_at("g2_func", 7, 5, 8'd1);
        wait_cyc(4);
        bus2.change_button = 1'b0;
        wait_cyc(8);
        bus2.change_button = 1'b1;
        wait_cyc(6);
        bus2.change_button = 1'b0;
        wait_cyc(20);
        check("g2_dropped_func", {6'd0, bus2.func_index}, 8'd1);
        check("g2_dropped_cnt", 8'(pulses2 - p0), 8'd1);
        bus2.change_button = 1'b1;
        expect_at("g2_live", 7, 5, 8'd2);
        wait_cyc(8);
        bus2.change_button = 1'b0;
        wait_cyc(12);

        check("sb_drained", 8'(sb.size()), 8'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
